// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single pixel-write port of the 160x120 VGA adapter among
//   NUM_REQ pixel producers. Arbitration is round-robin with valid/ready
//   handshakes, and at most one pixel is written per clock. A built-in clear
//   engine sweeps the whole frame with CLEAR_COLOUR. While the sweep runs it
//   pre-empts every producer.
//
//   Optional feature macro: VGA_PLOT_BOUNDS_CHECK_EN
//     When this macro is defined, a granted pixel outside the frame is accepted
//     but not plotted. Each such drop is counted on drop_count, which saturates
//     at 255.
//
//   Ports:
//     clk         system clock
//     reset       asynchronous, active-high reset
//     req_valid   per-requester pixel valid
//     req_x       packed x, requester i at [8i+7:8i]
//     req_y       packed y, requester i at [7i+6:7i]
//     req_colour  packed colour, requester i at [3i+2:3i]
//     req_ready   one-hot grant (combinational)
//     clear_req   single-cycle pulse that starts a full-frame clear
//     clear_busy  high while the sweep runs
//     clear_done  one-cycle pulse when the last clear pixel is on the outputs
//     x, y, colour, plot   registered write port to vga_adapter
//     drop_count  dropped out-of-range pixels (only with the macro defined)

module vga_plot_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned X_MAX        = 160,
    parameter int unsigned Y_MAX        = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
   ,output logic [7:0]           drop_count
`endif
);

    localparam int unsigned PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  X_LAST = 8'(X_MAX - 1);
    localparam logic [6:0]  Y_LAST = 7'(Y_MAX - 1);

    typedef enum logic {ST_ARB, ST_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [7:0]         cx_q, cx_d;
    logic [6:0]         cy_q, cy_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [2:0]         col_q, col_d;
    logic               plot_q, plot_d;
    logic               done_q, done_d;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
    logic [7:0]         drop_q, drop_d;
`endif

    logic [NUM_REQ-1:0] vld_hi;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [PW-1:0]      sel;
    logic [7:0]         px;
    logic [6:0]         py;
    logic [2:0]         pc;
    logic               last_px;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        done_d  = 1'b0;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
        drop_d  = drop_q;
`endif
        grant   = '0;
        found   = 1'b0;
        sel     = '0;
        px      = '0;
        py      = '0;
        pc      = '0;
        last_px = (cx_q == X_LAST) && (cy_q == Y_LAST);

        // Round-robin search: prefer valid requesters at or above the pointer,
        // then wrap around to the lowest index.
        vld_hi = req_valid & ({NUM_REQ{1'b1}} << ptr_q);
        cand   = (|vld_hi) ? vld_hi : req_valid;

        unique case (state_q)
            ST_ARB: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (!done_q) begin
                    // In the cycle where clear_done is on the outputs, no request is granted.
                    // Granting resumes on the cycle after it.
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (!found && cand[i]) begin
                            found = 1'b1;
                            sel   = PW'(i);
                        end
                    end
                    if (found) begin
                        grant = NUM_REQ'(1) << sel;
                        ptr_d = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            if (grant[i]) begin
                                px = req_x[8*i +: 8];
                                py = req_y[7*i +: 7];
                                pc = req_colour[3*i +: 3];
                            end
                        end
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
                        if ((px > X_LAST) || (py > Y_LAST)) begin
                            if (drop_q != 8'hFF) begin
                                drop_d = drop_q + 8'd1;
                            end
                        end else begin
                            x_d    = px;
                            y_d    = py;
                            col_d  = pc;
                            plot_d = 1'b1;
                        end
`else
                        x_d    = px;
                        y_d    = py;
                        col_d  = pc;
                        plot_d = 1'b1;
`endif
                    end
                end
            end
            ST_CLEAR: begin
                x_d    = cx_q;
                y_d    = cy_q;
                col_d  = CLEAR_COLOUR;
                plot_d = 1'b1;
                if (last_px) begin
                    state_d = ST_ARB;
                    done_d  = 1'b1;
                end else if (cx_q == X_LAST) begin
                    cx_d = '0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
            drop_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            done_q  <= done_d;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
            drop_q  <= drop_d;
`endif
        end
    end

    // A combinational grant must not leak out while reset is held.
    assign req_ready  = reset ? '0 : grant;
    // The state leaves CLEAR on the same edge that registers the last pixel.
    // As a result, busy falls in the same cycle as clear_done.
    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = done_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = col_q;
    assign plot       = plot_q;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
module tb_vga_plot_arbiter;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_x;
    logic [7*N-1:0] req_y;
    logic [3*N-1:0] req_colour;
    logic [N-1:0]   req_ready;
    logic           clear_req;
    logic           clear_busy;
    logic           clear_done;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
    logic [7:0]     drop_count;
    logic [7:0]     s_drop;
    int             mdrop;
`endif

    always #5 clk = ~clk;

    vga_plot_arbiter #(
        .NUM_REQ(N), .X_MAX(160), .Y_MAX(120), .CLEAR_COLOUR(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x),
        .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .x(x), .y(y), .colour(colour), .plot(plot)
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
       ,.drop_count(drop_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model / scoreboard
    logic [17:0] exp_q[$];
    logic [17:0] mlast;
    int          mptr;
    bit          mclear, mdone;
    int          mcx, mcy;
    logic [N-1:0] mpend;

    // values sampled at the last negedge
    logic [N-1:0] s_ready;
    logic         s_plot, s_busy, s_done;
    logic [7:0]   s_x;
    logic [6:0]   s_y;
    logic [2:0]   s_col;

    function automatic int oh(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic set_px(input int i, input int px, input int py, input int pc);
        req_x[8*i +: 8]      = 8'(px);
        req_y[7*i +: 7]      = 7'(py);
        req_colour[3*i +: 3] = 3'(pc);
    endtask

    task automatic tick();
        bit exp_plot;
        bit done_n;
        int gi;
        logic [N-1:0] exp_ready;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        @(negedge clk);
        s_ready = req_ready; s_plot = plot; s_busy = clear_busy; s_done = clear_done;
        s_x = x; s_y = y; s_col = colour;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
        s_drop = drop_count;
`endif
        if (reset) begin
            check("rst_plot", plot, 0);
            check("rst_xyc", {x, y, colour}, 0);
            check("rst_busy", clear_busy, 0);
            check("rst_done", clear_done, 0);
            check("rst_ready", req_ready, 0);
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
            check("rst_drop", drop_count, 0);
            mdrop = 0;
`endif
            exp_q.delete(); mlast = '0; mptr = 0; mclear = 0; mdone = 0; mpend = '0;
        end else begin
            for (int i = 0; i < N; i++) if (mpend[i]) check("valid_hold", req_valid[i], 1);
            exp_plot = (exp_q.size() > 0);
            check("plot", plot, exp_plot);
            if (exp_plot) mlast = exp_q.pop_front();
            check("pixel", {x, y, colour}, mlast);
            check("busy", clear_busy, mclear);
            check("done", clear_done, mdone);
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
            check("drop", drop_count, mdrop);
`endif
            exp_ready = '0;
            gi = -1;
            if (!mclear && !mdone && !clear_req)
                for (int k = 0; k < N; k++)
                    if (gi < 0 && req_valid[(mptr + k) % N]) gi = (mptr + k) % N;
            if (gi >= 0) exp_ready[gi] = 1'b1;
            check("ready", req_ready, exp_ready);
            mpend = req_valid & ~exp_ready;
            if (gi >= 0) begin
                px = req_x[8*gi +: 8];
                py = req_y[7*gi +: 7];
                pc = req_colour[3*gi +: 3];
                mptr = (gi + 1) % N;
`ifdef VGA_PLOT_BOUNDS_CHECK_EN
                if (px >= 160 || py >= 120) begin
                    if (mdrop < 255) mdrop++;
                end else
`endif
                exp_q.push_back({px, py, pc});
            end
            done_n = 0;
            if (mclear) begin
                exp_q.push_back({8'(mcx), 7'(mcy), 3'b000});
                if (mcx == 159 && mcy == 119) begin
                    mclear = 0; done_n = 1;
                end else if (mcx == 159) begin
                    mcx = 0; mcy++;
                end else begin
                    mcx++;
                end
            end else if (clear_req) begin
                mclear = 1; mcx = 0; mcy = 0;
            end
            mdone = done_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; clear_req = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int gl[6];
        int e3[3];
        int n, busy_n;
        bit seen;
        reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_colour = '0; clear_req = 1'b0;
        mdone = 0; mclear = 0; mcx = 0; mcy = 0; mptr = 0; mpend = '0; mlast = '0;
        tick(); tick();
        reset = 1'b0;

        // single requester, latency 1
        set_px(0, 10, 20, 4); set_px(1, 30, 40, 1); set_px(2, 70, 80, 2);
        req_valid = 3'b001;
        tick();
        check("t1_ready", s_ready, 3'b001);
        tick();
        check("t1_plot", s_plot, 1);
        check("t1_pix", {s_x, s_y, s_col}, {8'd10, 7'd20, 3'b100});

        // all three valid: strict rotation from 0
        do_reset();
        req_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin tick(); gl[t] = oh(s_ready); end
        for (int t = 0; t < 6; t++) check("rr111", gl[t], t % 3);
        tick();

        // 3'b110 from reset: 1,2,1
        do_reset();
        req_valid = 3'b110;
        e3 = '{1, 2, 1};
        for (int t = 0; t < 3; t++) begin tick(); check("rr110", oh(s_ready), e3[t]); end

        // full clear with requester 0 waiting
        do_reset();
        req_valid = 3'b001;
        tick();
        clear_req = 1'b1;
        tick();
        check("clr_ready", s_ready, 0);
        clear_req = 1'b0;
        busy_n = 0; n = 0; seen = 0;
        while (!seen && n < 20000) begin
            tick(); n++;
            if (s_busy) busy_n++;
            if (s_done) begin
                seen = 1;
                check("done_pix", {s_x, s_y, s_col}, {8'd159, 7'd119, 3'd0});
                check("done_busy", s_busy, 0);
            end
        end
        check("clr_done_seen", seen, 1);
        check("clr_busy_cycles", busy_n, 19200);
        tick();
        check("post_clr_ready", s_ready, 3'b001);

        // reset in the middle of a sweep
        do_reset();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (!(mcx == 50 && mcy == 30) && n < 20000) begin tick(); n++; end
        check("sweep_reach", (mcx == 50 && mcy == 30), 1);
        reset = 1'b1;
        tick();
        check("mid_rst_plot", s_plot, 0);
        check("mid_rst_busy", s_busy, 0);
        check("mid_rst_done", s_done, 0);
        reset = 1'b0;
        req_valid = 3'b111;
        tick();
        check("post_rst_grant", oh(s_ready), 0);
        repeat (10) tick();

`ifdef VGA_PLOT_BOUNDS_CHECK_EN
        do_reset();
        req_valid = 3'b001;
        set_px(0, 160, 5, 1);
        tick();
        set_px(0, 5, 120, 2);
        tick();
        check("oob_plot1", s_plot, 0);
        set_px(0, 159, 119, 7);
        tick();
        check("oob_plot2", s_plot, 0);
        tick();
        check("ib_plot", s_plot, 1);
        check("ib_pix", {s_x, s_y, s_col}, {8'd159, 7'd119, 3'd7});
        check("drop2", s_drop, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of the 160x120 VGA adapter (x, y, colour, plot) among NUM_REQ pixel producers (runner renderer, obstacle renderer, score/overlay).
- Each producer uses a valid/ready handshake. Arbitration is round-robin, and at most one pixel is written per clock.
- A built-in clear engine sweeps the whole frame with CLEAR_COLOUR on request and pre-empts all producers while it runs.
- The block sits between the game renderers and vga_adapter. Its plot output drives the adapter's plot input directly.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- X_MAX, 160, frame width in pixels.
- Y_MAX, 120, frame height in pixels.
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester pixel valid.
- req_x  in  8*NUM_REQ  packed x; requester i uses bits [8i+7:8i].
- req_y  in  7*NUM_REQ  packed y; requester i uses bits [7i+6:7i].
- req_colour  in  3*NUM_REQ  packed colour; requester i uses bits [3i+2:3i].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- clear_req  in  1  single-cycle pulse that starts a full-frame clear.
- clear_busy  out  1  high while the sweep runs.
- clear_done  out  1  one-cycle pulse after the last clear pixel.
- x  out  8  to adapter.
- y  out  7  to adapter.
- colour  out  3  to adapter.
- plot  out  1  write enable to adapter.

Behaviour:
- Reset (async, reset=1):
  - State goes to ARB and the round-robin pointer goes to 0.
  - x=0, y=0, colour=0, plot=0, clear_busy=0, clear_done=0.
  - req_ready=0 while reset is asserted.
- States:
  - ARB: clear_req=1 goes to CLEAR; otherwise stay in ARB.
  - CLEAR: leave for ARB after pixel (X_MAX-1, Y_MAX-1) is issued.
- Arbitration in ARB:
  - Search starts at the pointer p and wraps modulo NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - Transfer happens when req_valid[i] and req_ready[i] are both 1. After a transfer, p becomes (i+1) mod NUM_REQ.
  - With no valid requester, p holds and all ready bits are 0.
- Requester obligation: req_valid must stay high with stable data until accepted. Dropping valid before acceptance is illegal; the bench flags it.
- Output timing:
  - Registered, latency 1. An accepted pixel at cycle N appears on x/y/colour with plot=1 at cycle N+1.
  - With no transfer, plot=0 and x/y/colour hold their last values.
- Clear entry:
  - In the cycle clear_req=1 is seen in ARB, all req_ready bits are forced to 0. No transfer happens that cycle.
  - clear_busy rises on the next cycle.
- Clear sweep:
  - Counters cx (8 bits) and cy (7 bits) start at 0,0 and issue one pixel per cycle, x fastest.
  - cx wraps from X_MAX-1 to 0 and increments cy.
  - Every swept pixel is output with plot=1 and colour=CLEAR_COLOUR, following the same 1-cycle output latency.
  - A full sweep is X_MAX*Y_MAX = 19200 plot cycles.
- Clear completion:
  - clear_done pulses for exactly one cycle, in the cycle the final pixel appears on the outputs.
  - clear_busy falls in that same cycle.
  - Arbitration resumes the following cycle with p unchanged from before the clear.
- clear_req while in CLEAR is ignored. There is no restart.
- req_ready is all zeros for the whole of CLEAR.
- Reset mid-clear: outputs go to reset values immediately and the sweep is abandoned. clear_done is not pulsed.
- Requester coordinates are passed through unmodified, except as described under Optional Feature.

Optional Feature:
- Macro: VGA_PLOT_BOUNDS_CHECK_EN.
- Defined:
  - A granted pixel with x>=X_MAX or y>=Y_MAX is still accepted (ready/valid handshake completes and p advances).
  - It is not plotted: plot stays 0 the next cycle.
  - An extra output port drop_count (8 bits, reset 0) increments on each dropped pixel and saturates at 255.
- Not defined:
  - No range check; all accepted pixels are plotted as given.
  - The drop_count port is absent.

Test Plan:
- Reset, then req_valid=3'b001 with pixel (10,20,3'b100) -> req_ready=3'b001 in the same cycle; next cycle plot=1, x=10, y=20, colour=3'b100.
- req_valid=3'b111 held, each requester with distinct data, pointer starting at 0 -> grants 0,1,2,0,1,2 on consecutive cycles; plot=1 every cycle with matching data one cycle later.
- req_valid=3'b110 from reset (p=0) -> first grant to 1, then 2, then 1; requester 0 never granted.
- clear_req pulse while req_valid=3'b001:
  - req_ready=0 in the pulse cycle; clear_busy=1 for 19200 cycles.
  - Outputs sweep (0,0),(1,0)..(159,0),(0,1)..(159,119), all colour 000.
  - clear_done coincides with (159,119).
  - Requester 0 is granted the cycle after clear_done.
- Assert reset during a sweep at pixel (50,30) -> plot=0, clear_busy=0, no clear_done; after release, valid requests are granted normally starting from requester 0.
- With VGA_PLOT_BOUNDS_CHECK_EN defined, request (160,5) then (5,120) then (159,119):
  - The first two are accepted with plot=0 and drop_count reaches 2.
  - The third is plotted.
